// File: rtl/exp_stream_pkg.sv
// rtl/exp_stream_pkg.sv - shared defaults, derived widths and read-FSM states for the exponent bit streamer
package exp_stream_pkg;

    localparam int REGISTER_SIZE_DEF = 32;
    localparam int BITS_IN_EXP_DEF   = 2048;
    localparam int WORDS_DEF         = BITS_IN_EXP_DEF / REGISTER_SIZE_DEF;
    localparam int BIT_IDX_W_DEF     = $clog2(BITS_IN_EXP_DEF);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

    // Index width that stays legal (>= 1 bit) for degenerate sizes of one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exp_bank.sv
// rtl/exp_bank.sv - one exponent bank: word array, full flag, word write port and bit-select read port
module exp_bank
    import exp_stream_pkg::*;
#(
    parameter int REGISTER_SIZE = REGISTER_SIZE_DEF,
    parameter int WORDS         = WORDS_DEF,
    parameter int IDX_W         = BIT_IDX_W_DEF,
    localparam int PTR_W        = idx_width(WORDS),
    localparam int BSEL_W       = idx_width(REGISTER_SIZE)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     wr_en_i,
    input  logic [PTR_W-1:0]         wr_ptr_i,
    input  logic [REGISTER_SIZE-1:0] wr_data_i,
    input  logic                     set_full_i,
    input  logic                     clr_full_i,
    output logic                     full_o,
    input  logic [IDX_W-1:0]         rd_idx_i,
    output logic                     rd_bit_o
);

    logic [REGISTER_SIZE-1:0] mem_q [WORDS];
    logic                     full_q;
    logic                     full_d;
    logic [PTR_W-1:0]         rd_word;
    logic [BSEL_W-1:0]        rd_bsel;

    // Contents are not reset; the full flag alone decides whether they are meaningful.
    always_ff @(posedge clk_in) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_i] <= wr_data_i;
        end
    end

    always_comb begin
        full_d = full_q;
        if (set_full_i) begin
            full_d = 1'b1;
        end
        if (clr_full_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    assign rd_word  = PTR_W'(rd_idx_i / IDX_W'(REGISTER_SIZE));
    assign rd_bsel  = BSEL_W'(rd_idx_i % IDX_W'(REGISTER_SIZE));
    assign rd_bit_o = mem_q[rd_word][rd_bsel];
    assign full_o   = full_q;

endmodule

// File: rtl/exponent_bit_streamer.sv
// rtl/exponent_bit_streamer.sv - ping-pong exponent buffer serialising bits to the accumulator; EXP_MSB_FIRST_EN selects MSB-first order
module exponent_bit_streamer
    import exp_stream_pkg::*;
#(
    parameter int REGISTER_SIZE = REGISTER_SIZE_DEF,
    parameter int BITS_IN_EXP   = BITS_IN_EXP_DEF
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] block_in,
    input  logic                     block_valid_in,
    output logic                     block_ready_out,
    output logic                     bit_out,
    output logic                     bit_valid_out,
    input  logic                     consumed_in,
    output logic                     last_bit_out,
    output logic                     exp_done_out,
    output logic [1:0]               banks_full_out
);

    localparam int WORDS = BITS_IN_EXP / REGISTER_SIZE;
    localparam int IDX_W = idx_width(BITS_IN_EXP);
    localparam int PTR_W = idx_width(WORDS);

    rd_state_e        state_q, state_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             done_q, done_d;

    logic [1:0]       full;
    logic [1:0]       bank_bit;
    logic [IDX_W-1:0] rd_idx_eff;
    logic             accept;
    logic             wr_last;
    logic             last_idx;
    logic             streaming;
    logic             finish;

    assign block_ready_out = rst_in & ~full[wr_sel_q];
    assign accept          = block_valid_in & block_ready_out;
    assign wr_last         = accept && (wr_ptr_q == PTR_W'(WORDS - 1));
    assign streaming       = (state_q == STREAM);
    assign last_idx        = (bit_idx_q == IDX_W'(BITS_IN_EXP - 1));
    assign finish          = streaming && consumed_in && last_idx;

`ifdef EXP_MSB_FIRST_EN
    assign rd_idx_eff = IDX_W'(BITS_IN_EXP - 1) - bit_idx_q;
`else
    assign rd_idx_eff = bit_idx_q;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        exp_bank #(
            .REGISTER_SIZE (REGISTER_SIZE),
            .WORDS         (WORDS),
            .IDX_W         (IDX_W)
        ) u_bank (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .wr_en_i    (accept && (wr_sel_q == 1'(b))),
            .wr_ptr_i   (wr_ptr_q),
            .wr_data_i  (block_in),
            .set_full_i (wr_last && (wr_sel_q == 1'(b))),
            .clr_full_i (finish && (rd_sel_q == 1'(b))),
            .full_o     (full[b]),
            .rd_idx_i   (rd_idx_eff),
            .rd_bit_o   (bank_bit[b])
        );
    end

    always_comb begin
        state_d   = state_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        wr_ptr_d  = wr_ptr_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;

        if (accept) begin
            if (wr_last) begin
                wr_ptr_d = '0;
                wr_sel_d = ~wr_sel_q;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (full[rd_sel_q]) begin
                    state_d   = STREAM;
                    bit_idx_d = '0;
                end
            end
            STREAM: begin
                if (consumed_in) begin
                    if (last_idx) begin
                        // Jump straight into the other bank when it was already loaded.
                        done_d    = 1'b1;
                        rd_sel_d  = ~rd_sel_q;
                        bit_idx_d = '0;
                        state_d   = full[~rd_sel_q] ? STREAM : IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            wr_ptr_q  <= '0;
            bit_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            wr_ptr_q  <= wr_ptr_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
        end
    end

    assign bit_valid_out  = streaming;
    assign bit_out        = streaming & bank_bit[rd_sel_q];
    assign last_bit_out   = streaming & last_idx;
    assign exp_done_out   = done_q;
    assign banks_full_out = full;

endmodule
